// File: rtl/pc_fetch.sv
// Program counter and fetch sequencer ahead of the branch-target lookup table.
// Steps the PC, redirects on taken branches, sequences start/halt, keeps run statistics.
module pc_fetch #(
  parameter int PC_W     = 12,
  parameter int LBL_W    = 8,
  parameter int START_PC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_en,
  input  logic             branch_taken,
  input  logic [LBL_W-1:0] label,
  input  logic             halt_req,
  output logic [LBL_W-1:0] lut_label,
  input  logic [PC_W-1:0]  lut_target,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             flush,
  output logic             done,
  output logic             lut_miss,
  output logic [15:0]      cycle_count,
  output logic [7:0]       branch_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;

  localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       cyc_q, cyc_d;
  logic [7:0]        brc_q, brc_d;
  logic              miss_q, miss_d;
  logic              br_take;

  assign br_take   = branch_en & branch_taken;
  assign lut_label = label;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    brc_d   = brc_q;
    miss_d  = miss_q;
    flush   = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
          cyc_d   = '0;
          brc_d   = '0;
          miss_d  = 1'b0;
        end
      end
      RUN: begin
        // Stalled and halting cycles still count as run time.
        if (cyc_q != '1) cyc_d = cyc_q + 16'd1;
        if (halt_req) begin
          state_d = HALTED;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (br_take) begin
          flush = 1'b1;
          pc_d  = lut_target;
          if (brc_q != '1) brc_d = brc_q + 8'd1;
          // Target 0 is never assigned to a real label, so it flags an unknown label.
          if (lut_target == '0) miss_d = 1'b1;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      cyc_q   <= '0;
      brc_q   <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      brc_q   <= brc_d;
      miss_q  <= miss_d;
    end
  end

  assign pc           = pc_q;
  assign fetch_valid  = (state_q == RUN);
  assign done         = (state_q == HALTED);
  assign lut_miss     = miss_q;
  assign cycle_count  = cyc_q;
  assign branch_count = brc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: run sequencing, branches, stall, halt, wrap, miss flag, async reset.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst_n, start, stall, branch_en, branch_taken, halt_req;
  logic [7:0]  label, lut_label, branch_count;
  logic [11:0] lut_target, pc;
  logic        fetch_valid, flush, done, lut_miss;
  logic [15:0] cycle_count;

  int n_chk = 0;
  int n_fail = 0;

  pc_fetch #(.PC_W(12), .LBL_W(8), .START_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_en(branch_en), .branch_taken(branch_taken), .label(label),
    .halt_req(halt_req), .lut_label(lut_label), .lut_target(lut_target),
    .pc(pc), .fetch_valid(fetch_valid), .flush(flush), .done(done),
    .lut_miss(lut_miss), .cycle_count(cycle_count), .branch_count(branch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic en, input logic [7:0] lbl, input logic [11:0] tgt);
    branch_en = en; branch_taken = en; label = lbl; lut_target = tgt;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stall = 0; halt_req = 0;
    set_br(0, 8'd0, 12'd0);
    #12;
    chk("rst_pc", pc, 0);
    chk("rst_fv", fetch_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_miss", lut_miss, 0);
    chk("rst_cc", cycle_count, 0);
    chk("rst_bc", branch_count, 0);
    rst_n = 1'b1;
    step();
    chk("idle_pc_hold", pc, 0);
    chk("idle_fv", fetch_valid, 0);

    // start: first RUN cycle shows pc=0
    start = 1; step(); start = 0;
    chk("start_pc", pc, 0);
    chk("start_fv", fetch_valid, 1);
    chk("start_cc", cycle_count, 0);
    step(); chk("inc_pc1", pc, 1);
    step(); chk("inc_pc2", pc, 2);
    step(); chk("inc_pc3", pc, 3);
    chk("cc3", cycle_count, 3);
    step(); step();
    chk("pc5", pc, 5);

    // taken branch
    set_br(1, 8'd3, 12'd201); #1;
    chk("br_flush", flush, 1);
    chk("lut_label", lut_label, 3);
    step();
    chk("br_pc", pc, 201);
    chk("br_bc", branch_count, 1);
    chk("br_cc", cycle_count, 6);
    set_br(0, 8'd0, 12'd0); #1;
    chk("nobr_flush", flush, 0);
    step();
    chk("br_next", pc, 202);

    // branch_en without taken is a plain increment
    branch_en = 1; label = 8'd9; lut_target = 12'd900; #1;
    chk("nt_flush", flush, 0);
    step();
    chk("nt_pc", pc, 203);
    chk("nt_bc", branch_count, 1);
    chk("nt_cc", cycle_count, 8);

    // stall with a pending taken branch
    stall = 1; set_br(1, 8'd7, 12'd300); #1;
    chk("stall_flush", flush, 0);
    step(); chk("stall_pc1", pc, 203);
    step(); chk("stall_pc2", pc, 203);
    step(); chk("stall_pc3", pc, 203);
    chk("stall_bc", branch_count, 1);
    stall = 0; #1;
    chk("rel_flush", flush, 1);
    step();
    chk("rel_pc", pc, 300);
    chk("rel_cc", cycle_count, 12);
    chk("rel_bc", branch_count, 2);

    // redirect to 10, then halt with a taken branch present
    set_br(1, 8'd4, 12'd10); step();
    chk("to10", pc, 10);
    halt_req = 1; set_br(1, 8'd5, 12'd50); #1;
    chk("halt_flush", flush, 0);
    step();
    halt_req = 0; set_br(0, 8'd0, 12'd0);
    chk("halt_pc", pc, 10);
    chk("halt_done", done, 1);
    chk("halt_fv", fetch_valid, 0);
    chk("halt_cc", cycle_count, 14);
    chk("halt_bc", branch_count, 3);
    step();
    chk("halted_pc", pc, 10);
    chk("halted_cc", cycle_count, 14);
    chk("halted_done", done, 1);

    // restart from HALTED
    start = 1; step(); start = 0;
    chk("rs_pc", pc, 0);
    chk("rs_fv", fetch_valid, 1);
    chk("rs_done", done, 0);
    chk("rs_cc", cycle_count, 0);
    chk("rs_bc", branch_count, 0);

    // wrap 4095 -> 0
    set_br(1, 8'd1, 12'd4095); step();
    chk("w_pc", pc, 4095);
    set_br(0, 8'd0, 12'd0); step();
    chk("wrap_pc", pc, 0);
    chk("wrap_miss", lut_miss, 0);

    // unknown label: target 0
    set_br(1, 8'd200, 12'd0); step();
    chk("miss_pc", pc, 0);
    chk("miss_set", lut_miss, 1);
    chk("miss_bc", branch_count, 2);
    set_br(0, 8'd0, 12'd0); step();
    chk("miss_inc", pc, 1);
    // start during RUN is ignored
    start = 1; step(); start = 0;
    chk("run_start_pc", pc, 2);
    chk("run_start_miss", lut_miss, 1);
    set_br(1, 8'd6, 12'd77); step();
    chk("miss_sticky_pc", pc, 77);
    chk("miss_sticky", lut_miss, 1);
    chk("miss_bc3", branch_count, 3);
    set_br(0, 8'd0, 12'd0);

    // async reset mid-run, checked before the next edge
    #2 rst_n = 1'b0; #1;
    chk("ar_pc", pc, 0);
    chk("ar_fv", fetch_valid, 0);
    chk("ar_miss", lut_miss, 0);
    chk("ar_cc", cycle_count, 0);
    chk("ar_bc", branch_count, 0);
    chk("ar_done", done, 0);
    #3 rst_n = 1'b1;

    // branch_count saturation
    step();
    start = 1; step(); start = 0;
    set_br(1, 8'd2, 12'd100);
    repeat (260) step();
    set_br(0, 8'd0, 12'd0);
    chk("sat_bc", branch_count, 255);
    chk("sat_cc", cycle_count, 260);
    chk("sat_pc", pc, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
